// File: rtl/serial_cmp_ctrl.sv
// LSB-first serial magnitude comparator: streams one bit pair per clock through
// a single majority cell, reporting A>B (or A>=B with x_init=1) and A==B.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  input  logic                     x_init,
  output logic                     busy,
  output logic                     done,
  output logic                     result,
  output logic                     eq,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             s;
  logic             e;
  logic [CW-1:0]    cnt;
  logic             s_next;
  logic             e_next;

  // One comparison cell: bit 0 of the shift registers is always the current pair.
  always_comb begin
    s_next = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & s) | (~b_sh[0] & s);
    e_next = e & ~(a_sh[0] ^ b_sh[0]);
  end

  // cnt is cleared whenever RUN is left, so it doubles as bit_idx.
  assign bit_idx = cnt;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain s_next into result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s      <= 1'b0;
      e      <= 1'b1;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
      eq     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            s     <= x_init;
            e     <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            // Cancel without touching result/eq; the partial state is dropped.
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            s    <= s_next;
            e    <= e_next;
            if (cnt == LAST) begin
              result <= s_next;
              eq     <= e_next;
              done   <= 1'b1;
              busy   <= 1'b0;
              cnt    <= '0;
              state  <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl (WIDTH=8): expected results queued at
// start, compared when done pulses; covers abort, back-to-back and reset mid-run.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic res;
    logic eq;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             x_init;
  logic             busy;
  logic             done;
  logic             result;
  logic             eq;
  logic [2:0]       bit_idx;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_res = 1'b0;
  logic last_eq  = 1'b0;

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a_in    (a_in),
    .b_in    (b_in),
    .x_init  (x_init),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .eq      (eq),
    .bit_idx (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic x);
    return (a > b) || ((a == b) && x);
  endfunction

  // Drive a start in the current cycle and queue its expected outcome.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic x,
                       input bit with_abort);
    exp_t ex;
    a_in   = a;
    b_in   = b;
    x_init = x;
    start  = 1'b1;
    abort  = with_abort;
    ex.res = model_res(a, b, x);
    ex.eq  = (a == b);
    exp_q.push_back(ex);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Check WIDTH busy cycles, then the done cycle, popping the scoreboard.
  task automatic expect_run(input bit hold_start);
    exp_t ex;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || bit_idx !== i[2:0]) begin
        errors++;
        $display("FAIL run_cycle%0d: busy=%b done=%b bit_idx=%0d, expected busy=1 done=0 bit_idx=%0d",
                 i, busy, done, bit_idx, i);
      end
      if (hold_start) begin
        start  = (i < WIDTH - 1);
        a_in   = WIDTH'($urandom);
        b_in   = WIDTH'($urandom);
        x_init = ~x_init;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: done seen with empty queue, expected a pending result");
    end else begin
      ex = exp_q.pop_front();
      checks++;
      if (result !== ex.res || eq !== ex.eq) begin
        errors++;
        $display("FAIL result: result=%b eq=%b, expected result=%b eq=%b",
                 result, eq, ex.res, ex.eq);
      end
      last_res = ex.res;
      last_eq  = ex.eq;
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bit_idx !== 3'd0) begin
      errors++;
      $display("FAIL idle: done=%b busy=%b bit_idx=%0d, expected 0 0 0", done, busy, bit_idx);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 1'b0 || eq !== 1'b0 || bit_idx !== 3'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b result=%b eq=%b bit_idx=%0d, expected all 0",
               tag, busy, done, result, eq, bit_idx);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    x_init = 1'b0;
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // abort while idle must do nothing
    abort = 1'b1;
    idle_gap();
    abort = 1'b0;
    idle_gap();
  endtask

  task automatic test_basic();
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    expect_run(1'b0);
    idle_gap();
  endtask

  task automatic test_equal();
    issue(8'hA5, 8'hA5, 1'b0, 1'b0);
    expect_run(1'b0);
    idle_gap();
    issue(8'hA5, 8'hA5, 1'b1, 1'b0);
    expect_run(1'b0);
    idle_gap();
  endtask

  task automatic test_extremes();
    issue(8'h00, 8'hFF, 1'b1, 1'b0);
    expect_run(1'b0);
    idle_gap();
    issue(8'h80, 8'h7F, 1'b0, 1'b0);
    expect_run(1'b0);
    idle_gap();
    issue(8'hFF, 8'h00, 1'b0, 1'b0);
    expect_run(1'b0);
    idle_gap();
  endtask

  task automatic test_start_ignored();
    issue(8'h12, 8'h34, 1'b1, 1'b0);
    expect_run(1'b1);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    issue(8'hC3, 8'hC3, 1'b0, 1'b0);
    expect_run(1'b0);
    // start together with abort in the DONE cycle: start wins
    issue(8'h01, 8'h02, 1'b1, 1'b1);
    expect_run(1'b0);
    issue(8'h7E, 8'h7D, 1'b0, 1'b0);
    expect_run(1'b0);
    idle_gap();
  endtask

  task automatic test_abort();
    a_in   = 8'hF0;
    b_in   = 8'h0F;
    x_init = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bit_idx !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: bit_idx=%0d busy=%b, expected 3 1", bit_idx, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bit_idx !== 3'd0 ||
        result !== last_res || eq !== last_eq) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b bit_idx=%0d result=%b eq=%b, expected 0 0 0 %b %b",
               busy, done, bit_idx, result, eq, last_res, last_eq);
    end
    repeat (WIDTH + 2) idle_gap();
  endtask

  task automatic test_reset_mid_run();
    a_in   = 8'hFF;
    b_in   = 8'hFF;
    x_init = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bit_idx !== 3'd5) begin
      errors++;
      $display("FAIL reset_mid_pre: bit_idx=%0d, expected 5", bit_idx);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_run");
    @(negedge clk);
    rst_n    = 1'b1;
    last_res = 1'b0;
    last_eq  = 1'b0;
    issue(8'h33, 8'h34, 1'b1, 1'b0);
    expect_run(1'b0);
    idle_gap();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    for (int n = 0; n < 6; n++) begin
      a = WIDTH'($urandom);
      b = (n % 3 == 0) ? a : WIDTH'($urandom);
      issue(a, b, 1'($urandom), 1'b0);
      expect_run(1'b0);
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_extremes();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
# serial_cmp_ctrl

Sequencer for the right-to-left (LSB-first) comparison cell chain. It captures two WIDTH-bit words, streams one bit pair per clock through the comparison recurrence, starting from a programmable initial state x, and reports the final state. It reuses a single cell iteratively instead of a full combinational array. Host-side logic drives it with a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (>= 2)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a comparison; honoured only in IDLE or DONE
- abort  in  1  synchronous cancel of a running comparison
- a_in  in  WIDTH  operand A, sampled on the accepted start edge
- b_in  in  WIDTH  operand B, sampled on the accepted start edge
- x_init  in  1  initial chain state, sampled on the accepted start edge
- busy  out  1  high while bits are being processed (RUN)
- done  out  1  one-cycle pulse: result/eq valid
- result  out  1  final chain state; held until the next completed comparison
- eq  out  1  high if A == B; held like result
- bit_idx  out  $clog2(WIDTH)  index of the bit pair being processed (0 when not RUN)

## Operation
- Recurrence per bit i = 0..WIDTH-1, LSB first: s <= maj(a[i], ~b[i], s), i.e. (a & ~b) | (a & s) | (~b & s); s starts at x_init.
- Final s = 1 iff A > B, or A == B and x_init = 1. x_init=0 yields A>B; x_init=1 yields A>=B.
- eq tracker: e starts at 1; e <= e & ~(a[i] ^ b[i]).
- FSM states:
  - IDLE: busy=0. start=1 -> latch a_in, b_in, x_init; s<=x_init; e<=1; cnt<=0; go RUN.
  - RUN: busy=1. Process bit cnt; cnt<=cnt+1. When cnt==WIDTH-1, go DONE after processing. abort=1 -> IDLE with no bit processed that cycle; result/eq unchanged; no done.
  - DONE: done=1 for this cycle; result<=s and eq<=e are registered on entry. Next state is IDLE, or RUN if start=1 (back-to-back, with new operands latched).
- start in RUN is ignored; latched operands are not disturbed.
- abort in IDLE or DONE has no effect. abort and start in the same DONE cycle: start wins.
- Operands are held in internal shift/index registers; a_in/b_in may change freely after the accepting edge.

## Timing
- Reset (async assert, rst_n low): state=IDLE, busy=0, done=0, result=0, eq=0, bit_idx=0, cnt=0, s=0, e=1. Release is sampled synchronously; the first start is honoured on the first edge with rst_n high.
- Latency: start accepted at edge t -> RUN during cycles t+1..t+WIDTH -> done=1 during cycle t+WIDTH+1. result/eq change at the same edge that raises done.
- Throughput: back-to-back starts give one result every WIDTH+1 cycles.
- bit_idx equals cnt during RUN, 0 otherwise.
- Reset mid-RUN: immediate return to reset values; the partial result is discarded.
- cnt does not wrap inside a transaction. The exit condition is the explicit cnt==WIDTH-1 compare.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, x_init=0, start at edge t -> busy high for cycles t+1..t+8; done pulses at cycle t+9; result=1, eq=0.
- A=B=0xA5 with x_init=0 -> result=0, eq=1. Repeat with x_init=1 -> result=1, eq=1.
- A=0x00, B=0xFF, x_init=1 -> result=0, eq=0. A=0x80, B=0x7F, x_init=0 -> result=1 (MSB decides over lower bits).
- Start pulse held during RUN with different operands -> ignored; first result is unchanged. start asserted in the DONE cycle -> second done exactly 9 cycles later with the correct second result.
- abort at bit_idx=3 -> IDLE next cycle, no done, result/eq keep their prior values. rst_n pulsed low at bit_idx=5 -> all outputs go to reset values immediately; a fresh start then completes normally.
